umi_mem_endpoint: RTL and testbench
===================================

// Module: umi_mem_endpoint
// PURPOSE
//  Single-beat UMI memory target; consumes the request stream leaving umi_splitter (umi_req_out).
//  Executes read, write and posted-write requests against a DEPTH x DW internal RAM.
//  Returns read and write responses on a UMI output, which the system loops back toward the requester.
//  One request is outstanding at a time; no reordering is possible.
// PARAMETERS
//  DW     256  data width in bits; DW/8 = bytes per RAM row
//  AW     64   address width
//  CW     32   command width
//  DEPTH  64   RAM rows (power of 2)
// PORTS
//  clk               in   1   clock; all logic on posedge
//  nreset            in   1   asynchronous active-low reset
//  umi_in_valid      in   1   request valid
//  umi_in_cmd        in   CW  request command
//  umi_in_dstaddr    in   AW  request target address
//  umi_in_srcaddr    in   AW  requester return address
//  umi_in_data       in   DW  write data, byte 0 at bits [7:0]
//  umi_in_ready      out  1   request accepted when valid&ready
//  umi_out_valid     out  1   response valid
//  umi_out_cmd       out  CW  response command
//  umi_out_dstaddr   out  AW  response destination (= request srcaddr)
//  umi_out_srcaddr   out  AW  response source (= request dstaddr)
//  umi_out_data      out  DW  read data, byte 0 at bits [7:0]
//  umi_out_ready     in   1   response accepted when valid&ready
//  err_pulse         out  1   one-cycle strobe per dropped request
// BEHAVIOUR
//  Command fields:
//   opcode = cmd[4:0], size = cmd[7:5], len = cmd[15:8].
//   nbytes = (len+1) << size.
//  Opcodes:
//   READ = 5'h01, WRITE = 5'h03, POSTED = 5'h05.
//   RESP_READ = 5'h02, RESP_WRITE = 5'h04.
//  Address decode:
//   off = dstaddr[log2(DW/8)-1:0].
//   row = dstaddr[log2(DW/8) +: log2(DEPTH)].
//   Upper address bits are ignored, so addresses alias.
//  Reset values: all outputs 0 except umi_in_ready = 1. FSM resets to IDLE.
//   RAM contents are not reset.
//  FSM IDLE -> ACCESS -> {RESP | IDLE}:
//   IDLE: umi_in_ready = 1. On handshake, register cmd, addresses and data; go to ACCESS.
//   ACCESS: umi_in_ready = 0.
//    - Write: byte-enable write of nbytes at off. Data byte i goes to row byte off+i.
//    - Read: issue RAM read of row (1-cycle synchronous RAM).
//    - POSTED returns to IDLE. READ and WRITE go to RESP.
//   RESP: umi_out_valid = 1.
//    - Response cmd = request cmd with opcode replaced by RESP_READ or RESP_WRITE.
//    - Read data is shifted down by off; bytes at or above nbytes are zero.
//    - Write response data is 0.
//    - Outputs stay stable until umi_out_ready; on handshake go to IDLE, valid drops the next cycle.
//  Latency:
//   Request accepted in cycle N gives umi_out_valid in cycle N+2.
//   Peak throughput: 1 req per 3 cycles, or 1 per 2 for posted writes.
//  Error (checked in ACCESS):
//   - Condition: unsupported opcode, nbytes > DW/8, or off+nbytes > DW/8.
//   - Action: no RAM access, no response, err_pulse = 1 for one cycle, return to IDLE.
//  Boundaries:
//   - umi_in_valid while not IDLE is held off (ready = 0), not dropped.
//   - umi_out_ready held low stalls indefinitely in RESP.
//   - nreset asserted mid-operation discards the pending request immediately.
//   - A write followed by a read of the same row returns the new data (no bypass is needed).
// STRUCTURE
//  umi_mem_pkg:
//   - opcode localparams
//   - cmd field slice functions (opcode, size, len, nbytes)
//   - state enum {IDLE, ACCESS, RESP}
//  Sub-module umi_mem_ram: DEPTH x DW synchronous RAM with per-byte write enable and registered read.
// TESTING
//  1. WRITE size=2 len=1 @0x10, data=0x1122334455667788
//     -> RESP_WRITE, out_dstaddr=in_srcaddr, out_srcaddr=0x10, data=0.
//  2. READ size=0 len=7 @0x10 after test 1 -> RESP_READ, data[63:0]=0x1122334455667788, rest 0.
//  3. POSTED size=0 len=0 @0x3F data=0xAB, then READ len=0 @0x3F -> one response only, data=0xAB.
//  4. READ size=3 len=3 @0x1C (crosses 32B row) -> err_pulse once, no response, next request served.
//  5. out_ready low for 10 cycles during RESP -> outputs stable, in_ready=0, single handshake on release.
//  6. nreset low in ACCESS of a READ -> out_valid=0, in_ready=1 after release, no stale response.

Source files
------------

// File: rtl/umi_mem_pkg.sv
// Shared definitions for the UMI memory endpoint.
//   - opcode constants for requests and responses
//   - command field slicing helpers (opcode, size, len, nbytes)
//   - endpoint FSM state encoding
// Only the low 16 command bits carry fields the endpoint interprets.
// The helpers therefore take that slice, so they work for any CW >= 16.
package umi_mem_pkg;

  localparam logic [4:0] OPC_READ       = 5'h01;
  localparam logic [4:0] OPC_RESP_READ  = 5'h02;
  localparam logic [4:0] OPC_WRITE      = 5'h03;
  localparam logic [4:0] OPC_RESP_WRITE = 5'h04;
  localparam logic [4:0] OPC_POSTED     = 5'h05;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  function automatic logic [4:0] cmd_opcode(input logic [15:0] cmd);
    return cmd[4:0];
  endfunction

  function automatic logic [2:0] cmd_size(input logic [15:0] cmd);
    return cmd[7:5];
  endfunction

  function automatic logic [7:0] cmd_len(input logic [15:0] cmd);
    return cmd[15:8];
  endfunction

  // (len+1) << size; the largest value is 256 << 7 = 32768, which fits in 16 bits.
  function automatic logic [15:0] cmd_nbytes(input logic [15:0] cmd);
    logic [15:0] n;
    n = {8'd0, cmd_len(cmd)} + 16'd1;
    return n << cmd_size(cmd);
  endfunction

endpackage

// File: rtl/umi_mem_ram.sv
// DEPTH x DW single-port synchronous RAM.
// It has a per-byte write enable and a registered read port.
// Ports:
//   clk      in  clock
//   we_i     in  write strobe; bytes selected by be_i are written to addr_i
//   be_i     in  byte enables, bit b covers wdata_i[8*b +: 8]
//   addr_i   in  row address
//   wdata_i  in  write data
//   re_i     in  read strobe; rdata_o updates one cycle later
//   rdata_o  out registered read data; holds its value while re_i is low
// Contents are not reset.
module umi_mem_ram #(
  parameter int DW    = 256,
  parameter int DEPTH = 64,
  localparam int RW   = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            we_i,
  input  logic [DW/8-1:0] be_i,
  input  logic [RW-1:0]   addr_i,
  input  logic [DW-1:0]   wdata_i,
  input  logic            re_i,
  output logic [DW-1:0]   rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int b = 0; b < DW/8; b++) begin
        if (be_i[b]) mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
    if (re_i) rdata_o <= mem_q[addr_i];
  end

endmodule

// File: rtl/umi_mem_endpoint.sv
// Single-beat UMI memory target.
// It runs READ, WRITE and POSTED requests against an internal DEPTH x DW RAM.
// Only one request is in flight at a time.
// Ports:
//   clk, nreset                clock, asynchronous active-low reset
//   umi_in_*                   request stream (valid/ready)
//   umi_out_*                  response stream (valid/ready)
//   err_pulse                  one-cycle strobe for each dropped request
//   dbg_state_o                current FSM state (umi_mem_pkg::state_e encoding)
// Handshake: a transfer happens on a rising edge where valid and ready are both 1.
//   A source holds valid and its payload stable until that edge.
//   A sink may raise or drop ready freely.
//   Here, umi_in_ready is 1 exactly while IDLE.
//   umi_out_valid and the response fields stay stable from entry into RESP until the handshake.
module umi_mem_endpoint
  import umi_mem_pkg::*;
#(
  parameter int DW    = 256,
  parameter int AW    = 64,
  parameter int CW    = 32,
  parameter int DEPTH = 64
) (
  input  logic          clk,
  input  logic          nreset,
  input  logic          umi_in_valid,
  input  logic [CW-1:0] umi_in_cmd,
  input  logic [AW-1:0] umi_in_dstaddr,
  input  logic [AW-1:0] umi_in_srcaddr,
  input  logic [DW-1:0] umi_in_data,
  output logic          umi_in_ready,
  output logic          umi_out_valid,
  output logic [CW-1:0] umi_out_cmd,
  output logic [AW-1:0] umi_out_dstaddr,
  output logic [AW-1:0] umi_out_srcaddr,
  output logic [DW-1:0] umi_out_data,
  input  logic          umi_out_ready,
  output logic          err_pulse,
  output logic [1:0]    dbg_state_o
);

  localparam int          NB   = DW / 8;
  localparam int          BW   = $clog2(NB);
  localparam int          RW   = $clog2(DEPTH);
  localparam logic [16:0] NB17 = 17'(NB);

  state_e        state_q;
  logic [CW-1:0] req_cmd_q;
  logic [AW-1:0] req_dst_q, req_src_q;
  logic [DW-1:0] req_data_q;
  logic          in_ready_q, out_valid_q, err_q, resp_rd_q;
  logic [CW-1:0] out_cmd_q;
  logic [AW-1:0] out_dst_q, out_src_q;

  // Decode of the captured request; these are stable from ACCESS through RESP.
  logic [4:0]    opc_d;
  logic [15:0]   nbytes_d;
  logic [BW-1:0] off_d;
  logic [RW-1:0] row_d;
  logic [16:0]   end_d;
  logic          is_read_d, is_write_d, is_posted_d, err_d;

  assign opc_d       = cmd_opcode(req_cmd_q[15:0]);
  assign nbytes_d    = cmd_nbytes(req_cmd_q[15:0]);
  assign off_d       = req_dst_q[BW-1:0];
  assign row_d       = req_dst_q[BW +: RW];
  assign end_d       = 17'(off_d) + 17'(nbytes_d);
  assign is_read_d   = (opc_d == OPC_READ);
  assign is_posted_d = (opc_d == OPC_POSTED);
  assign is_write_d  = (opc_d == OPC_WRITE) || is_posted_d;
  assign err_d       = !(is_read_d || is_write_d) || (17'(nbytes_d) > NB17) || (end_d > NB17);

  // Byte lanes [off, off+nbytes) of the row. Request byte i lands on row byte off+i.
  logic [NB-1:0] be_d;
  logic [DW-1:0] wdata_d;
  always_comb begin
    be_d = '0;
    for (int j = 0; j < NB; j++) begin
      be_d[j] = (17'(j) >= 17'(off_d)) && (17'(j) < end_d);
    end
  end
  assign wdata_d = req_data_q << {off_d, 3'b000};

  logic          ram_we, ram_re;
  logic [DW-1:0] ram_rdata;
  assign ram_we = (state_q == ST_ACCESS) && is_write_d && !err_d;
  assign ram_re = (state_q == ST_ACCESS) && is_read_d && !err_d;

  umi_mem_ram #(.DW(DW), .DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .we_i    (ram_we),
    .be_i    (be_d),
    .addr_i  (row_d),
    .wdata_i (wdata_d),
    .re_i    (ram_re),
    .rdata_o (ram_rdata)
  );

  // Read data is aligned down to byte 0, and bytes at or above nbytes are cleared.
  // The inputs are registers (RAM output and request regs) that do not change in RESP,
  // so this stays stable while the response is stalled.
  logic [DW-1:0] rd_shift_d, rd_mask_d;
  always_comb begin
    rd_shift_d = ram_rdata >> {off_d, 3'b000};
    rd_mask_d  = '0;
    for (int j = 0; j < NB; j++) begin
      rd_mask_d[j*8 +: 8] = (17'(j) < 17'(nbytes_d)) ? 8'hFF : 8'h00;
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q     <= ST_IDLE;
      req_cmd_q   <= '0;
      req_dst_q   <= '0;
      req_src_q   <= '0;
      req_data_q  <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_cmd_q   <= '0;
      out_dst_q   <= '0;
      out_src_q   <= '0;
      resp_rd_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (umi_in_valid && in_ready_q) begin
            req_cmd_q  <= umi_in_cmd;
            req_dst_q  <= umi_in_dstaddr;
            req_src_q  <= umi_in_srcaddr;
            req_data_q <= umi_in_data;
            in_ready_q <= 1'b0;
            state_q    <= ST_ACCESS;
          end
        end
        ST_ACCESS: begin
          if (err_d) begin
            err_q      <= 1'b1;
            in_ready_q <= 1'b1;
            state_q    <= ST_IDLE;
          end else if (is_posted_d) begin
            in_ready_q <= 1'b1;
            state_q    <= ST_IDLE;
          end else begin
            out_valid_q <= 1'b1;
            out_cmd_q   <= {req_cmd_q[CW-1:5], is_read_d ? OPC_RESP_READ : OPC_RESP_WRITE};
            out_dst_q   <= req_src_q;
            out_src_q   <= req_dst_q;
            resp_rd_q   <= is_read_d;
            state_q     <= ST_RESP;
          end
        end
        ST_RESP: begin
          if (umi_out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          state_q     <= ST_IDLE;
        end
      endcase
    end
  end

  assign umi_in_ready    = in_ready_q;
  assign umi_out_valid   = out_valid_q;
  assign umi_out_cmd     = out_cmd_q;
  assign umi_out_dstaddr = out_dst_q;
  assign umi_out_srcaddr = out_src_q;
  assign umi_out_data    = (out_valid_q && resp_rd_q) ? (rd_shift_d & rd_mask_d) : '0;
  assign err_pulse       = err_q;
  assign dbg_state_o     = state_q;

endmodule

// File: tb/tb_umi_mem_endpoint.sv
// Directed bench for umi_mem_endpoint.
// Inputs change 1ns after a rising edge, and outputs are checked at the same point.
module tb_umi_mem_endpoint;

  localparam int DW = 256, AW = 64, CW = 32, DEPTH = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic nreset;
  always #5 clk = ~clk;

  logic          umi_in_valid;
  logic [CW-1:0] umi_in_cmd;
  logic [AW-1:0] umi_in_dstaddr, umi_in_srcaddr;
  logic [DW-1:0] umi_in_data;
  logic          umi_in_ready;
  logic          umi_out_valid;
  logic [CW-1:0] umi_out_cmd;
  logic [AW-1:0] umi_out_dstaddr, umi_out_srcaddr;
  logic [DW-1:0] umi_out_data;
  logic          umi_out_ready;
  logic          err_pulse;
  logic [1:0]    dbg_state_o;

  umi_mem_endpoint #(.DW(DW), .AW(AW), .CW(CW), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .nreset          (nreset),
    .umi_in_valid    (umi_in_valid),
    .umi_in_cmd      (umi_in_cmd),
    .umi_in_dstaddr  (umi_in_dstaddr),
    .umi_in_srcaddr  (umi_in_srcaddr),
    .umi_in_data     (umi_in_data),
    .umi_in_ready    (umi_in_ready),
    .umi_out_valid   (umi_out_valid),
    .umi_out_cmd     (umi_out_cmd),
    .umi_out_dstaddr (umi_out_dstaddr),
    .umi_out_srcaddr (umi_out_srcaddr),
    .umi_out_data    (umi_out_data),
    .umi_out_ready   (umi_out_ready),
    .err_pulse       (err_pulse),
    .dbg_state_o     (dbg_state_o)
  );

  // ---------------- scoreboard counters ----------------
  int n_checks = 0;
  int n_fail   = 0;
  int resp_cnt = 0;
  int err_cnt  = 0;

  always @(posedge clk) begin
    if (nreset && umi_out_valid && umi_out_ready) resp_cnt++;
    if (nreset && err_pulse) err_cnt++;
  end

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Presents a request and returns 1ns after the accepting edge, when the FSM is in ACCESS.
  task automatic send_req(input string tag, input logic [CW-1:0] cmd, input logic [AW-1:0] dst,
                          input logic [AW-1:0] src, input logic [DW-1:0] data);
    int n;
    n = 0;
    umi_in_valid   = 1'b1;
    umi_in_cmd     = cmd;
    umi_in_dstaddr = dst;
    umi_in_srcaddr = src;
    umi_in_data    = data;
    while (!umi_in_ready && n < 50) begin
      tick();
      n++;
    end
    check({tag, "_accept"}, 256'(n < 50), 256'(1));
    tick();
    umi_in_valid = 1'b0;
  endtask

  localparam logic [AW-1:0] SRC = 64'hAAAA_0000_0000_1234;

  initial begin
    logic stable;
    nreset         = 1'b0;
    umi_in_valid   = 1'b0;
    umi_in_cmd     = '0;
    umi_in_dstaddr = '0;
    umi_in_srcaddr = '0;
    umi_in_data    = '0;
    umi_out_ready  = 1'b1;
    tick(); tick();

    // reset state
    check("rst_in_ready", 256'(umi_in_ready), 256'(1));
    check("rst_out_valid", 256'(umi_out_valid), 256'(0));
    check("rst_out_cmd", 256'(umi_out_cmd), 256'(0));
    check("rst_out_dst", 256'(umi_out_dstaddr), 256'(0));
    check("rst_out_src", 256'(umi_out_srcaddr), 256'(0));
    check("rst_out_data", umi_out_data, 256'(0));
    check("rst_err", 256'(err_pulse), 256'(0));
    check("rst_state", 256'(dbg_state_o), 256'(0));
    nreset = 1'b1;
    tick();

    // 1: WRITE size=2 len=1 (8 bytes) @0x10
    send_req("t1", 32'h0000_0143, 64'h10, SRC, 256'h1122334455667788);
    check("t1_acc_ready", 256'(umi_in_ready), 256'(0));
    check("t1_acc_state", 256'(dbg_state_o), 256'(1));
    check("t1_acc_valid", 256'(umi_out_valid), 256'(0));
    tick();
    check("t1_valid", 256'(umi_out_valid), 256'(1));
    check("t1_cmd", 256'(umi_out_cmd), 256'h144);
    check("t1_dst", 256'(umi_out_dstaddr), 256'(SRC));
    check("t1_src", 256'(umi_out_srcaddr), 256'h10);
    check("t1_data", umi_out_data, 256'(0));
    tick();
    check("t1_valid_drop", 256'(umi_out_valid), 256'(0));
    check("t1_ready_back", 256'(umi_in_ready), 256'(1));

    // 2: READ size=0 len=7 @0x10 returns the bytes just written
    send_req("t2", 32'h0000_0701, 64'h10, 64'h55, '0);
    tick();
    check("t2_valid", 256'(umi_out_valid), 256'(1));
    check("t2_cmd", 256'(umi_out_cmd), 256'h702);
    check("t2_data", umi_out_data, 256'h1122334455667788);
    tick();

    // 3: POSTED 1 byte @0x3F (last byte of row 1): no response
    send_req("t3p", 32'h0000_0005, 64'h3F, 64'h66, 256'hAB);
    tick();
    check("t3_no_resp", 256'(umi_out_valid), 256'(0));
    check("t3_ready", 256'(umi_in_ready), 256'(1));
    tick();
    check("t3_no_resp2", 256'(umi_out_valid), 256'(0));
    send_req("t3r", 32'h0000_0001, 64'h3F, 64'h66, '0);
    tick();
    check("t3_cmd", 256'(umi_out_cmd), 256'h2);
    check("t3_data", umi_out_data, 256'hAB);
    tick();
    // Upper address bits are ignored: 0x83F aliases to row 1, offset 31.
    send_req("t3a", 32'h0000_0001, 64'h83F, 64'h66, '0);
    tick();
    check("t3_alias_data", umi_out_data, 256'hAB);
    tick();

    // 4: READ size=3 len=3 (32 bytes) @0x1C crosses the row
    send_req("t4", 32'h0000_0361, 64'h1C, 64'h77, '0);
    tick();
    check("t4_err", 256'(err_pulse), 256'(1));
    check("t4_no_resp", 256'(umi_out_valid), 256'(0));
    check("t4_ready", 256'(umi_in_ready), 256'(1));
    tick();
    check("t4_err_drop", 256'(err_pulse), 256'(0));
    check("t4_no_resp2", 256'(umi_out_valid), 256'(0));
    // unsupported opcode
    send_req("t4o", 32'h0000_0007, 64'h0, 64'h77, '0);
    tick();
    check("t4o_err", 256'(err_pulse), 256'(1));
    // nbytes = 64 > 32 at offset 0
    send_req("t4n", 32'h0000_01A1, 64'h0, 64'h77, '0);
    tick();
    check("t4n_err", 256'(err_pulse), 256'(1));
    check("t4n_no_resp", 256'(umi_out_valid), 256'(0));
    // the next request is still served
    send_req("t4f", 32'h0000_0701, 64'h10, 64'h77, '0);
    tick();
    check("t4f_data", umi_out_data, 256'h1122334455667788);
    tick();

    // 5: response stalled for 10 cycles; a new request is held off meanwhile
    umi_out_ready = 1'b0;
    send_req("t5w", 32'h0000_0303, 64'h40, 64'h88, 256'hDEADBEEF);
    tick();
    umi_in_valid   = 1'b1;
    umi_in_cmd     = 32'h0000_0301;
    umi_in_dstaddr = 64'h40;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (umi_out_valid !== 1'b1 || umi_out_cmd !== 32'h304 || umi_in_ready !== 1'b0 ||
          umi_out_dstaddr !== 64'h88 || umi_out_srcaddr !== 64'h40 || umi_out_data !== '0)
        stable = 1'b0;
    end
    check("t5_stable", 256'(stable), 256'(1));
    check("t5_state", 256'(dbg_state_o), 256'(2));
    umi_out_ready = 1'b1;
    tick();
    check("t5_valid_drop", 256'(umi_out_valid), 256'(0));
    check("t5_ready", 256'(umi_in_ready), 256'(1));
    send_req("t5r", 32'h0000_0301, 64'h40, 64'h88, '0);
    tick();
    check("t5r_data", umi_out_data, 256'hDEADBEEF);
    tick();

    // 6: reset while a READ is in ACCESS
    send_req("t6", 32'h0000_0701, 64'h10, 64'h99, '0);
    nreset = 1'b0;
    #1;
    check("t6_rst_valid", 256'(umi_out_valid), 256'(0));
    check("t6_rst_ready", 256'(umi_in_ready), 256'(1));
    check("t6_rst_state", 256'(dbg_state_o), 256'(0));
    tick(); tick();
    nreset = 1'b1;
    tick(); tick(); tick();
    check("t6_no_stale", 256'(umi_out_valid), 256'(0));
    check("t6_ready", 256'(umi_in_ready), 256'(1));
    send_req("t6r", 32'h0000_0701, 64'h10, 64'h99, '0);
    tick();
    check("t6r_data", umi_out_data, 256'h1122334455667788);
    tick();
    tick();

    // totals: 8 responses, 3 dropped requests
    check("resp_total", 256'(resp_cnt), 256'(8));
    check("err_total", 256'(err_cnt), 256'(3));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
